// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes a MIPS instruction word into the ALU control
// bundle for EX. A main output register and one skid register sit behind
// valid/ready handshakes, so back-pressure from EX never loses or repeats
// an instruction.

package alu_decode_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_LUI = 4'b1011,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1111
  } alu_op_e;

  typedef struct packed {
    alu_op_e     alu_control;
    logic [4:0]  shamt;
    logic [31:0] imm32;
    logic        use_imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

endpackage

module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [4:0]      shamt,
  output logic [XLEN-1:0] imm32,
  output logic            use_imm,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      dest,
  output logic            reg_write,
  output logic            illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  bundle_t     dec;

  bundle_t     out_q;
  bundle_t     skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;

  logic        in_fire;
  logic        out_fire;
  logic        out_free;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  // Combinational decode of the incoming instruction word.
  // NOTE: every field gets a default before the case so no path leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    dec             = '0;
    dec.alu_control = ALU_ADD;
    dec.rs          = instr[25:21];
    dec.rt          = instr[20:16];
    case (opcode)
      6'h00: begin
        dec.dest      = instr[15:11];
        dec.reg_write = 1'b1;
        case (funct)
          6'h00:        begin dec.alu_control = ALU_SLL; dec.shamt = instr[10:6]; end
          6'h02:        begin dec.alu_control = ALU_SRL; dec.shamt = instr[10:6]; end
          6'h03:        begin dec.alu_control = ALU_SRA; dec.shamt = instr[10:6]; end
          6'h20, 6'h21: dec.alu_control = ALU_ADD;
          6'h22, 6'h23: dec.alu_control = ALU_SUB;
          6'h24:        dec.alu_control = ALU_AND;
          6'h25:        dec.alu_control = ALU_OR;
          6'h26:        dec.alu_control = ALU_XOR;
          6'h27:        dec.alu_control = ALU_NOR;
          6'h2A, 6'h2B: dec.alu_control = ALU_SLT;
          default:      dec.illegal     = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23: begin
        dec.alu_control = ALU_ADD;
        dec.imm32       = imm_sext;
        dec.use_imm     = 1'b1;
        dec.dest        = instr[20:16];
        dec.reg_write   = 1'b1;
      end
      6'h0A: begin
        dec.alu_control = ALU_SLT;
        dec.imm32       = imm_sext;
        dec.use_imm     = 1'b1;
        dec.dest        = instr[20:16];
        dec.reg_write   = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        case (opcode[1:0])
          2'b00:   dec.alu_control = ALU_AND;
          2'b01:   dec.alu_control = ALU_OR;
          2'b10:   dec.alu_control = ALU_XOR;
          default: dec.alu_control = ALU_LUI;
        endcase
        // lui passes the raw 16 bits; the ALU applies the <<16.
        dec.imm32     = imm_zext;
        dec.use_imm   = 1'b1;
        dec.dest      = instr[20:16];
        dec.reg_write = 1'b1;
      end
      6'h2B: begin
        dec.alu_control = ALU_ADD;
        dec.imm32       = imm_sext;
        dec.use_imm     = 1'b1;
      end
      6'h04, 6'h05: begin
        // Branches compare rs against rt; the offset rides along in imm32.
        dec.alu_control = ALU_SUB;
        dec.imm32       = imm_sext;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal bundles are neutralised but still flow through the pipe.
    if (dec.illegal) begin
      dec.alu_control = ALU_ADD;
      dec.shamt       = '0;
      dec.imm32       = '0;
      dec.use_imm     = 1'b0;
      dec.dest        = '0;
      dec.reg_write   = 1'b0;
    end
  end

  // in_ready comes straight off the skid flop, so it is registered.
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;
  assign out_free = out_fire | ~out_valid_q;

  // Valid bits and output payload: flush first, then drain skid, then accept.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Skid payload capture while the output is stalled.
  // NOTE: the skid data register has no reset; skid_valid_q qualifies it,
  // so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (!flush && !out_free && in_fire) begin
      skid_q <= dec;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = out_q.alu_control;
  assign shamt       = out_q.shamt;
  assign imm32       = out_q.imm32;
  assign use_imm     = out_q.use_imm;
  assign rs          = out_q.rs;
  assign rt          = out_q.rt;
  assign dest        = out_q.dest;
  assign reg_write   = out_q.reg_write;
  assign illegal     = out_q.illegal;

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode pipeline stage that turns a fetched MIPS instruction word into the 4-bit ALU control code, shamt and operand selects consumed by the ALU in the EX stage.
- Sits between fetch and EX with valid/ready handshakes on both sides and a 2-entry skid buffer, so EX back-pressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath and instruction width; the only supported value is 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered instructions
- in_valid  input  1  fetch offers instr
- in_ready  output  1  stage can accept instr this cycle
- instr  input  32  MIPS instruction word
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  EX accepts bundle
- alu_control  output  4  ALU opcode, encodings listed below
- shamt  output  5  instr[10:6] for sll/srl/sra, otherwise 0
- imm32  output  32  extended immediate
- use_imm  output  1  operand2 = imm32 (1) or rt register (0)
- rs  output  5  instr[25:21]
- rt  output  5  instr[20:16]
- dest  output  5  write-back register index
- reg_write  output  1  instruction writes dest
- illegal  output  1  unsupported opcode/funct

Behaviour:
- Reset (async, rst_n=0): out_valid=0; in_ready=1; skid empty; all payload outputs 0.
- Handshake: transfer on in_valid&&in_ready and on out_valid&&out_ready. Latency is 1 cycle, from input transfer to out_valid, when the buffer is empty. Payload holds stable while out_valid&&!out_ready.
- Buffer:
  - Main output register plus one skid register. in_ready is registered: in_ready = skid empty.
  - If input arrives while the output is stalled, the instruction goes to skid and in_ready drops next cycle.
  - When the output transfers, skid (if full) moves to output and in_ready rises next cycle.
  - Simultaneous output transfer and input transfer with skid empty: the new instruction goes straight to the output register.
  - Order is strictly FIFO.
- flush:
  - Next edge: out_valid=0, skid empty, in_ready=1.
  - An in_valid handshake in the flush cycle is discarded.
  - flush wins over all other events.
- ALU control encodings:
  - AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111
  - SLL=1000, SRL=1001, SRA=1010, LUI=1011, NOR=1100, XOR=1111
- R-type (opcode 0): dest=rd, use_imm=0, reg_write=1, imm32=0.
  - funct 0x00→SLL, 0x02→SRL, 0x03→SRA, with shamt=instr[10:6].
  - 0x20/0x21→ADD, 0x22/0x23→SUB, 0x24→AND, 0x25→OR, 0x26→XOR, 0x27→NOR, 0x2A/0x2B→SLT.
  - Every other funct is illegal. sllv/srlv/srav are not supported.
- I-type: dest=rt, use_imm=1, reg_write=1.
  - addi 0x08, addiu 0x09 → ADD, sign-extended.
  - slti 0x0A → SLT, sign-extended.
  - andi 0x0C → AND, ori 0x0D → OR, xori 0x0E → XOR, all zero-extended.
  - lui 0x0F → LUI, imm32 = zero-extended instr[15:0]; the ALU performs the <<16.
  - lw 0x23 → ADD, sign-extended.
  - sw 0x2B → ADD, sign-extended, reg_write=0, dest=0.
  - beq 0x04, bne 0x05 → SUB, use_imm=0, reg_write=0, dest=0, imm32 = sign-extended offset.
- Illegal instructions:
  - illegal=1, alu_control=ADD, reg_write=0, use_imm=0, shamt=0, dest=0.
  - The bundle still passes through the handshake; it is not dropped.
- NOP (0x00000000) decodes as sll $0,$0,0 with reg_write=1 and dest=0. Write-back ignores $0.
- Reset asserted mid-stall: the buffered instruction is lost and outputs return to reset values immediately.

Test Plan:
- Reset then add $3,$1,$2 (0x00221820), out_ready=1 → next cycle out_valid=1, alu_control=0010, dest=3, rs=1, rt=2, use_imm=0, reg_write=1.
- sra $4,$5,7 (0x000521C3) → alu_control=1010, shamt=7, rt=5, dest=4.
- Immediates:
  - addi $2,$0,-1 (0x2002FFFF) → imm32=0xFFFFFFFF, use_imm=1, alu_control=0010.
  - ori $2,$0,0xFFFF (0x3402FFFF) → imm32=0x0000FFFF, alu_control=0001.
  - lui $1,0x1234 (0x3C011234) → alu_control=1011, imm32=0x00001234.
- Back-pressure:
  - Hold out_ready=0 and send three instructions back-to-back → first held at output, second in skid, in_ready=0, third not accepted.
  - Release out_ready → bundles appear in order with no gaps or duplicates.
- Raise flush with output and skid full plus in_valid=1 → next cycle out_valid=0, in_ready=1. Nothing from before the flush, including the flush-cycle input, ever appears.
- Illegal and store cases:
  - funct 0x04 (sllv) → illegal=1, reg_write=0, alu_control=0010.
  - sw (0xAC220004) → reg_write=0, imm32=4, alu_control=0010.
